// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the RegisterFile write-port arbiter:
//   - default geometry of the 64-bit, 32-entry RegisterFile
//   - index of the hardwired-zero register
//   - arbiter state encoding and grant encodings
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot so the grant value doubles as the LastGrant encoding.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_A    = 2'b01,
        GRANT_B    = 2'b10
    } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Valid/ready writeback request bundle for the two requesters
// (A = execute, B = memory/load).
//   master : requester side, drives valid/RW/BusW and receives ready
//   slave  : arbiter side, receives valid/RW/BusW and drives ready
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
);

    logic                  ReqAValid;
    logic [ADDR_WIDTH-1:0] ReqARW;
    logic [DATA_WIDTH-1:0] ReqABusW;
    logic                  ReqAReady;

    logic                  ReqBValid;
    logic [ADDR_WIDTH-1:0] ReqBRW;
    logic [DATA_WIDTH-1:0] ReqBBusW;
    logic                  ReqBReady;

    modport master (
        output ReqAValid, ReqARW, ReqABusW,
        output ReqBValid, ReqBRW, ReqBBusW,
        input  ReqAReady, ReqBReady
    );

    modport slave (
        input  ReqAValid, ReqARW, ReqABusW,
        input  ReqBValid, ReqBRW, ReqBBusW,
        output ReqAReady, ReqBReady
    );

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The grant is combinational from the valids and
// the pointer; the pointer moves to the losing side after every grant and
// holds when nothing is granted.
// Ports:
//   Clk, Reset     : clock, synchronous active-high reset (pointer -> A)
//   Enable         : arbitration allowed; when low no grant is issued
//   AValid, BValid : request lines
//   Grant          : GRANT_NONE / GRANT_A / GRANT_B, never both sides
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   Enable,
    input  logic   AValid,
    input  logic   BValid,
    output grant_t Grant
);

    grant_t pointer;

    always_comb begin
        // NOTE: default assigned first so every path drives Grant; no latch.
        Grant = GRANT_NONE;
        if (Enable) begin
            if (AValid && BValid) begin
                Grant = pointer;
            end else if (AValid) begin
                Grant = GRANT_A;
            end else if (BValid) begin
                Grant = GRANT_B;
            end
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (Reset) begin
            pointer <= GRANT_A;
        end else if (Grant == GRANT_A) begin
            pointer <= GRANT_B;
        end else if (Grant == GRANT_B) begin
            pointer <= GRANT_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the RegisterFile write port. After reset it sweeps INIT_VALUE into
// X0..X(ZERO_REG-1), then shares the port between requesters A and B with
// round-robin valid/ready arbitration. Writes to ZERO_REG are accepted but
// dropped (RegWr stays low).
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   req        : requester bundle (slave side), readys combinational
//   RW, BusW   : registered write index/data; hold when nothing is granted
//   RegWr      : registered write enable
//   InitDone   : high from the edge that issues the last init write
//   LastGrant  : registered winner of the most recent grant (01 A, 10 B)
//   WriteCount : registered, saturating count of committed writes
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int                    DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int                    ZERO_REG   = regfile_pkg::ZERO_REG,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    regfile_write_arbiter_if.slave req,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] BusW,
    output logic                  RegWr,
    output logic                  InitDone,
    output logic [1:0]            LastGrant,
    output logic [CNT_WIDTH-1:0]  WriteCount
);

    localparam logic [ADDR_WIDTH-1:0] ZeroIdx  = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LastInit = ADDR_WIDTH'(ZERO_REG - 1);
    localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;

    regfile_pkg::state_t   state;
    logic [ADDR_WIDTH-1:0] initCnt;
    regfile_pkg::grant_t   grant;
    logic [ADDR_WIDTH-1:0] grantRW;
    logic [DATA_WIDTH-1:0] grantBusW;
    logic                  grantCommits;

    rr_arbiter2 u_arbiter (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (state == regfile_pkg::RUN),
        .AValid (req.ReqAValid),
        .BValid (req.ReqBValid),
        .Grant  (grant)
    );

    assign req.ReqAReady = (grant == regfile_pkg::GRANT_A);
    assign req.ReqBReady = (grant == regfile_pkg::GRANT_B);

    assign grantRW      = (grant == regfile_pkg::GRANT_B) ? req.ReqBRW   : req.ReqARW;
    assign grantBusW    = (grant == regfile_pkg::GRANT_B) ? req.ReqBBusW : req.ReqABusW;
    assign grantCommits = (grant != regfile_pkg::GRANT_NONE) && (grantRW != ZeroIdx);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= regfile_pkg::INIT;
            initCnt    <= '0;
            RW         <= '0;
            BusW       <= '0;
            RegWr      <= 1'b0;
            InitDone   <= 1'b0;
            LastGrant  <= regfile_pkg::GRANT_NONE;
            WriteCount <= '0;
        end else begin
            case (state)
                regfile_pkg::INIT: begin
                    RW      <= initCnt;
                    BusW    <= INIT_VALUE;
                    RegWr   <= 1'b1;
                    initCnt <= initCnt + 1'b1;
                    if (WriteCount != CntMax) begin
                        WriteCount <= WriteCount + 1'b1;
                    end
                    // The edge issuing the last init write also enters RUN.
                    if (initCnt == LastInit) begin
                        state    <= regfile_pkg::RUN;
                        InitDone <= 1'b1;
                    end
                end
                regfile_pkg::RUN: begin
                    if (grant != regfile_pkg::GRANT_NONE) begin
                        RW        <= grantRW;
                        BusW      <= grantBusW;
                        RegWr     <= grantCommits;
                        LastGrant <= grant;
                        if (grantCommits && (WriteCount != CntMax)) begin
                            WriteCount <= WriteCount + 1'b1;
                        end
                    end else begin
                        RegWr <= 1'b0;
                    end
                end
                default: begin
                    state <= regfile_pkg::INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (RW/BusW/RegWr) of the 64-bit, 32-entry RegisterFile. X31 always reads as zero.
- After reset, it sequences a zero-initialisation sweep of X0..X30.
- After the sweep, it shares the write port between two writeback requesters: A (execute) and B (memory/load). Arbitration is round-robin with valid/ready handshakes.
- It sits between the writeback stages and the RegisterFile write inputs.

Parameters:
- DATA_WIDTH, 64, width of BusW and request data.
- ADDR_WIDTH, 5, width of register indices.
- ZERO_REG, 31, hardwired-zero register index; writes to it are dropped.
- INIT_VALUE, 0, value written to every register during the init sweep.
- CNT_WIDTH, 16, width of the committed-write counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqAValid  in  1  requester A has a write pending.
- ReqARW  in  ADDR_WIDTH  A's destination register.
- ReqABusW  in  DATA_WIDTH  A's write data.
- ReqAReady  out  1  A's request is accepted this cycle.
- ReqBValid  in  1  requester B has a write pending.
- ReqBRW  in  ADDR_WIDTH  B's destination register.
- ReqBBusW  in  DATA_WIDTH  B's write data.
- ReqBReady  out  1  B's request is accepted this cycle.
- RW  out  ADDR_WIDTH  to RegisterFile RW; registered.
- BusW  out  DATA_WIDTH  to RegisterFile BusW; registered.
- RegWr  out  1  to RegisterFile RegWr; registered.
- InitDone  out  1  high once the init sweep has been issued.
- LastGrant  out  2  registered; 2'b01 = A, 2'b10 = B, 2'b00 = none/init.
- WriteCount  out  CNT_WIDTH  registered count of committed regfile writes; saturates.

Behaviour:

Reset:
- Reset is sampled at the rising edge of Clk.
- Reset values: state=INIT, init counter=0, RW=0, BusW=0, RegWr=0, InitDone=0, LastGrant=0, WriteCount=0, round-robin pointer=A.
- Reset asserted in any state, including mid-sweep, aborts the current activity and restarts from INIT at the next edge.
- In-flight handshakes are not preserved across reset.

States:
- INIT:
  - Each edge registers RW=cnt, BusW=INIT_VALUE, RegWr=1, then increments cnt.
  - When the edge issues cnt == ZERO_REG-1 (30), the state moves to RUN.
  - ReqAReady and ReqBReady are held at 0 throughout INIT.
- RUN:
  - InitDone=1, registered, so it rises on the same edge that enters RUN.
  - RUN stays until Reset.

Timing relative to Reset deassertion at edge k:
- Edge k+1: RW=0. Edge k+31: RW=30, state=RUN, InitDone=1.
- The first requester write can appear on the outputs at edge k+32.

Arbitration (RUN only; ready is combinational from the valids and the pointer):
- Only A valid: ReqAReady=1.
- Only B valid: ReqBReady=1.
- Both valid: grant the pointer side only.
- Neither valid: both ready=0.
- Never both ready in the same cycle.
- On a grant: pointer <= the non-granted side, and LastGrant records the winner.
- With no grant, the pointer and LastGrant hold their values.

Write port:
- On a handshake (valid & ready) at edge N, the outputs take the granted RW and BusW on edge N, so latency is 1 cycle.
- RegWr=1 unless the granted RW == ZERO_REG, in which case RegWr=0.
- A dropped X31 write is still accepted and still updates the pointer and LastGrant.
- With no handshake, RegWr <= 0; RW and BusW hold their previous values.
- Outputs stay stable for a full Clk period, so the RegisterFile may sample on either edge.

WriteCount:
- Increments on every edge that registers RegWr=1, including the 31 init writes.
- Saturates at all-ones.
- Dropped X31 writes do not count.

Requesters must hold valid, RW and data stable until ready; the arbiter never drops a valid request.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and ZERO_REG constants.
  - The state enum (INIT, RUN).
  - The grant encodings GRANT_NONE, GRANT_A, GRANT_B.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant plus pointer), reusable elsewhere.
- The init sequencer and output registers stay in the top module.

Test Plan:
1. Reset, then deassert for 31 cycles -> RW steps 0..30 with RegWr=1 and BusW=0; InitDone=1 at edge k+31; both readys 0 throughout; RegisterFile reads X0..X30 = 0 afterwards; WriteCount=31.
2. Assert Reset at edge k+10 of the sweep for 1 cycle -> RegWr=0, InitDone=0, and the sweep restarts at RW=0 on the first edge after Reset drops.
3. In RUN, A only {RW=5, data=0x1000} -> ReqAReady=1; the next edge gives RW=5, BusW=0x1000, RegWr=1, LastGrant=01; then RA=5 reads 0x1000.
4. Both valid continuously (A: X6=0x1010, B: X7=0xABCD), pointer initially A -> grants alternate A,B,A,B; each grant is 1 cycle; LastGrant toggles 01/10; readys are never both 1.
5. B valid with RW=31, data=0x12345678 -> ReqBReady=1, RegWr stays 0, WriteCount unchanged, LastGrant=10; RA=31 still reads 0.
6. No valid for 3 cycles after a write -> RegWr=0, RW/BusW hold, pointer unchanged; the next A/B contention grants the side opposite the last winner.
